multicycle_ctrl_p: RTL and testbench

//  Parametrised multi-cycle CPU controller with integrated address/ALU datapath regs.

---
 rtl/mcu_pkg.sv | 75 +++++++
 rtl/mcu_alu.sv | 23 ++
 rtl/multicycle_ctrl_p.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_p.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM state type and
// instruction field extractors.
//
// Instruction layout (MSB first): [op:3][rd:RA_W][rs1:RA_W][rs2:RA_W | imm:IMM_W]
// where IMM_W = INSTR_W - 3 - 2*RA_W. rs2 occupies the low RA_W bits of the
// rs2/imm field; imm is the whole field and is sign-extended.
//
// The extractors take the instruction zero-extended to MaxW bits plus the
// geometry as arguments, so one set of functions serves every parameterisation.
package mcu_pkg;

    localparam int unsigned MaxW   = 64;  // widest instruction/datapath supported
    localparam int unsigned MaxRaW = 8;   // widest register address supported

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_BEQ   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StDone,
        StHalt
    } state_t;

    function automatic logic [2:0] get_op(input logic [MaxW-1:0] instr,
                                          input int unsigned instr_w);
        logic [MaxW-1:0] t;
        t = instr >> (instr_w - 3);
        return t[2:0];
    endfunction

    function automatic logic [MaxW-1:0] ra_mask(input int unsigned ra_w);
        return (MaxW'(1) << ra_w) - MaxW'(1);
    endfunction

    function automatic logic [MaxRaW-1:0] get_rd(input logic [MaxW-1:0] instr,
                                                 input int unsigned ra_w,
                                                 input int unsigned instr_w);
        logic [MaxW-1:0] t;
        t = (instr >> (instr_w - 3 - ra_w)) & ra_mask(ra_w);
        return t[MaxRaW-1:0];
    endfunction

    function automatic logic [MaxRaW-1:0] get_rs1(input logic [MaxW-1:0] instr,
                                                  input int unsigned ra_w,
                                                  input int unsigned instr_w);
        logic [MaxW-1:0] t;
        t = (instr >> (instr_w - 3 - 2 * ra_w)) & ra_mask(ra_w);
        return t[MaxRaW-1:0];
    endfunction

    function automatic logic [MaxRaW-1:0] get_rs2(input logic [MaxW-1:0] instr,
                                                  input int unsigned ra_w);
        logic [MaxW-1:0] t;
        t = instr & ra_mask(ra_w);
        return t[MaxRaW-1:0];
    endfunction

    // Sign-extends the low imm_w bits to MaxW bits.
    function automatic logic [MaxW-1:0] get_imm(input logic [MaxW-1:0] instr,
                                                input int unsigned imm_w);
        logic [MaxW-1:0] t;
        t = instr << (MaxW - imm_w);
        return $signed(t) >>> (MaxW - imm_w);
    endfunction

endpackage

// File: rtl/mcu_alu.sv
// Combinational datapath ALU for the multi-cycle controller.
//
// Ports:
//   a_i, b_i  operands (DATA_W)
//   sub_i     1: res_o = a_i - b_i, 0: res_o = a_i + b_i (both modulo 2**DATA_W)
//   res_o     result
//   eq_o      a_i == b_i, used for the BEQ decision
module mcu_alu #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] res_o,
    output logic              eq_o
);

    always_comb begin
        res_o = sub_i ? (a_i - b_i) : (a_i + b_i);
        eq_o  = (a_i == b_i);
    end

endmodule

// File: rtl/multicycle_ctrl_p.sv
// Multi-cycle CPU controller with integrated PC/IR/operand/ALU/load-data registers.
// One instruction in flight; fetch and data accesses share a single req/ack port.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   run                     start enable, only looked at in IDLE
//   mem_req/we/addr/wdata   memory request, held stable until mem_ack
//   mem_rdata, mem_ack      read data and transfer-complete handshake
//   rf_ra1/rf_ra2           register file read addresses (rs1; rs2 or rd)
//   rf_rd1/rf_rd2           combinational register file read data
//   rf_we/rf_wa/rf_wd       one-cycle register write strobe, address, data
//   pc_out                  current PC
//   retire                  one-cycle pulse per completed instruction
//   halted                  high while in HALT
//
// Assumes DATA_W >= INSTR_W (instructions are fetched through the data bus) and
// INSTR_W - 3 - 2*RA_W >= 1.
module multicycle_ctrl_p
    import mcu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RA_W    = 2,
    parameter int unsigned INSTR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [RA_W-1:0]   rf_ra1,
    output logic [RA_W-1:0]   rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);

    localparam int unsigned IMM_W = INSTR_W - 3 - 2 * RA_W;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;
    logic               taken_q, taken_d;

    // Instruction decode
    logic [MaxW-1:0]   ir_wide;
    logic [MaxW-1:0]   imm_wide;
    logic [2:0]        op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic              is_arith;
    logic              is_mem_op;

    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [MaxW-1:0]   alu_wide;
    logic [ADDR_W-1:0] mem_ea;

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_eq;
    logic              unused_bits;

    assign ir_wide   = MaxW'(ir_q);
    assign op        = get_op(ir_wide, INSTR_W);
    assign rd        = RA_W'(get_rd(ir_wide, RA_W, INSTR_W));
    assign rs1       = RA_W'(get_rs1(ir_wide, RA_W, INSTR_W));
    assign rs2       = RA_W'(get_rs2(ir_wide, RA_W));
    assign imm_wide  = get_imm(ir_wide, IMM_W);
    assign imm_data  = DATA_W'(imm_wide);
    assign imm_addr  = ADDR_W'(imm_wide);
    assign is_arith  = (op == OP_ADD) || (op == OP_SUB);
    assign is_mem_op = (op == OP_LOAD) || (op == OP_STORE);
    assign pc_inc    = pc_q + ADDR_W'(1);

    // Widen first so the effective address zero-extends when DATA_W < ADDR_W.
    assign alu_wide  = MaxW'(alu_q);
    assign mem_ea    = ADDR_W'(alu_wide);

    // Only the low parts of the widened helpers are consumed.
    assign unused_bits = ^{imm_wide, alu_wide};

    // Loads/stores add the immediate; everything else uses the B operand.
    assign alu_b = is_mem_op ? imm_data : b_q;

    mcu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i   (a_q),
        .b_i   (alu_b),
        .sub_i (op == OP_SUB),
        .res_o (alu_res),
        .eq_o  (alu_eq)
    );

    // Register file addressing follows the IR directly; STORE data and the BEQ
    // comparand come from the rd field.
    assign rf_ra1 = rs1;
    assign rf_ra2 = is_arith ? rs2 : rd;
    assign rf_wa  = rd;
    assign pc_out = pc_q;

    // ---------------------------------------------------------------- FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (run) state_d = StFetch;
            StFetch:  if (mem_ack) state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_HALT:                                    state_d = StHalt;
                    OP_ADD, OP_SUB, OP_BEQ, OP_LOAD, OP_STORE:  state_d = StExec;
                    default:                                    state_d = StDone;
                endcase
            end
            StExec: begin
                if (is_arith) begin
                    state_d = StWb;
                end else if (is_mem_op) begin
                    state_d = StMem;
                end else begin
                    state_d = StDone;
                end
            end
            StMem:    if (mem_ack) state_d = (op == OP_LOAD) ? StWb : StDone;
            StWb:     state_d = StDone;
            StDone:   state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------- FSM outputs
    // Request outputs derive only from state and held registers, so they stay
    // stable for the whole wait and vanish as soon as reset clears the state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_we     = 1'b0;
        rf_wd     = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_addr = mem_ea;
                if (op == OP_STORE) begin
                    mem_we    = 1'b1;
                    mem_wdata = b_q;
                end
            end
            StWb: begin
                rf_we = 1'b1;
                rf_wd = (op == OP_LOAD) ? mdr_q : alu_q;
            end
            StDone:  retire = 1'b1;
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------ datapath registers
    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        taken_d = taken_q;
        unique case (state_q)
            StFetch:  if (mem_ack) ir_d = mem_rdata[INSTR_W-1:0];
            StDecode: begin
                a_d = rf_rd1;
                b_d = rf_rd2;
            end
            StExec: begin
                alu_d   = alu_res;
                taken_d = (op == OP_BEQ) && alu_eq;
                tgt_d   = pc_inc + imm_addr;
            end
            StMem:    if (mem_ack && (op == OP_LOAD)) mdr_d = mem_rdata;
            StDone: begin
                pc_d    = taken_q ? tgt_q : pc_inc;
                taken_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            tgt_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            taken_q <= taken_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_p.sv
module tb_multicycle_ctrl_p;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic run2 = 1'b0;

    always #5 clk = ~clk;

    // DUT 1: default geometry
    logic          mem_req, mem_we, mem_ack, rf_we, retire, halted;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] mem_wdata, mem_rdata, rf_rd1, rf_rd2, rf_wd;
    logic [RW-1:0] rf_ra1, rf_ra2, rf_wa;

    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] rf1 [4];
    int fw = 0;
    int mw = 0;
    int wcnt, xfer_n;

    assign mem_rdata = mem1[mem_addr[7:0]];
    assign rf_rd1    = rf1[rf_ra1];
    assign rf_rd2    = rf1[rf_ra2];
    // First transfer after reset is the fetch (fw waits); later ones use mw.
    assign mem_ack   = mem_req && (wcnt == ((xfer_n == 0) ? fw : mw));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt   <= 0;
            xfer_n <= 0;
        end else if (mem_req && mem_ack) begin
            wcnt   <= 0;
            xfer_n <= xfer_n + 1;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    multicycle_ctrl_p dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    // DUT 2: DATA_W=32, RA_W=3, IMM_W=7, zero-wait memory
    logic        mem_req2, mem_we2, rf_we2, retire2, halted2;
    logic [15:0] mem_addr2, pc_out2;
    logic [31:0] mem_wdata2, mem_rdata2, rf_rd1_2, rf_rd2_2, rf_wd2;
    logic [2:0]  rf_ra1_2, rf_ra2_2, rf_wa2;
    logic [31:0] mem2 [256];
    logic [31:0] rf2 [8];

    assign mem_rdata2 = mem2[mem_addr2[7:0]];
    assign rf_rd1_2   = rf2[rf_ra1_2];
    assign rf_rd2_2   = rf2[rf_ra2_2];

    multicycle_ctrl_p #(.DATA_W(32), .ADDR_W(16), .RA_W(3), .INSTR_W(16)) dut2 (
        .clk(clk), .reset(reset), .run(run2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ack(1'b1),
        .rf_ra1(rf_ra1_2), .rf_ra2(rf_ra2_2), .rf_rd1(rf_rd1_2), .rf_rd2(rf_rd2_2),
        .rf_we(rf_we2), .rf_wa(rf_wa2), .rf_wd(rf_wd2),
        .pc_out(pc_out2), .retire(retire2), .halted(halted2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        run   = 1'b0;
        run2  = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_mem1();
        for (int i = 0; i < 256; i++) mem1[i] = 16'hE000;
        for (int i = 0; i < 4; i++) rf1[i] = '0;
    endtask

    // Pulse run; returns at the negedge of the first FETCH cycle.
    task automatic start1();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Waits for n retires (bounded), then one more negedge so pc_out is updated.
    task automatic wait_retires(input int n, input int budget, output int got);
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (rf_we) rf1[rf_wa] = rf_wd;
            if (retire) got++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        string            name;
        logic [15:0]      instr;
        logic [3:0][15:0] r;          // preset {r3, r2, r1, r0}
        int               fw;
        int               mw;
        int               exp_cyc;    // fetch-to-retire, fetch is cycle 1
        int               exp_we;     // number of rf writes
        int               exp_we_cyc;
        logic [1:0]       exp_wa;
        logic [15:0]      exp_wd;
        logic [15:0]      exp_pc;
        bit               is_ld;
        bit               is_st;
        logic [15:0]      exp_addr;
        logic [15:0]      exp_wdata;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int cyc, ret, we_n, we_cyc, nacc, got;
    logic [1:0]  got_wa;
    logic [15:0] got_wd, x_addr, x_wdata, p_addr, p_wdata;
    logic        x_we, p_we, pend, stable;
    int          req_cnt, ret_cnt;
    bit          seen;

    initial begin
        vecs[0] = '{"add", 16'h1A02, {16'h0, 16'h7, 16'h5, 16'h0}, 0, 0, 5, 1, 4, 2'd3,
                    16'd12, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[1] = '{"sub", 16'h2202, {16'h0, 16'h5, 16'h3, 16'h0}, 0, 0, 5, 1, 4, 2'd0,
                    16'hFFFE, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[2] = '{"load", 16'h93FF, {16'h0, 16'h0, 16'h10, 16'h0}, 0, 2, 8, 1, 7, 2'd2,
                    16'hBEEF, 16'h1, 1'b1, 1'b0, 16'h000F, 16'h0};
        vecs[3] = '{"store", 16'hB204, {16'h0, 16'h1234, 16'h20, 16'h0}, 1, 2, 8, 0, 0, 2'd0,
                    16'h0, 16'h1, 1'b0, 1'b1, 16'h0024, 16'h1234};
        vecs[4] = '{"beq_ne", 16'h53FE, {16'h0, 16'h2, 16'h1, 16'h0}, 0, 0, 4, 0, 0, 2'd0,
                    16'h0, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[5] = '{"beq_eq", 16'h53FE, {16'h0, 16'h9, 16'h9, 16'h0}, 0, 0, 4, 0, 0, 2'd0,
                    16'h0, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[6] = '{"nop3", 16'h6000, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, 3, 0, 0, 2'd0,
                    16'h0, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[7] = '{"nop6_wait", 16'hC000, {16'h0, 16'h0, 16'h0, 16'h0}, 2, 0, 5, 0, 0, 2'd0,
                    16'h0, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[8] = '{"add_wrap_wait", 16'h1A02, {16'h0, 16'h2, 16'hFFFF, 16'h0}, 3, 0, 8, 1, 7,
                    2'd3, 16'h1, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[9] = '{"add_r0", 16'h0603, {16'h4000, 16'h0, 16'h0, 16'h0}, 0, 0, 5, 1, 4, 2'd0,
                    16'h8000, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0};

        // Reset state
        fill_mem1();
        do_reset();
        chk("reset_mem_outs", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
        chk("reset_rf_outs", {rf_we, rf_wa, rf_wd, rf_ra1, rf_ra2}, '0);
        chk("reset_status", {pc_out, retire, halted}, '0);
        @(negedge clk);
        chk("idle_no_req", {31'd0, mem_req}, '0);

        // Table-driven single instructions at pc=0
        for (int v = 0; v < NV; v++) begin
            fill_mem1();
            mem1[0]    = vecs[v].instr;
            mem1[15]   = 16'hBEEF;
            for (int i = 0; i < 4; i++) rf1[i] = vecs[v].r[i];
            fw = vecs[v].fw;
            mw = vecs[v].mw;
            do_reset();
            start1();
            cyc = 1; ret = 0; we_n = 0; we_cyc = 0; nacc = 0;
            got_wa = '0; got_wd = '0; x_addr = '0; x_wdata = '0; x_we = 1'b0;
            pend = 1'b0; stable = 1'b1; p_addr = '0; p_wdata = '0; p_we = 1'b0;
            while (ret == 0 && cyc <= 40) begin
                if (pend && (!mem_req || mem_addr != p_addr || mem_we != p_we ||
                             mem_wdata != p_wdata)) stable = 1'b0;
                pend    = mem_req && !mem_ack;
                p_addr  = mem_addr;
                p_we    = mem_we;
                p_wdata = mem_wdata;
                if (mem_req && mem_ack) begin
                    if (nacc > 0) begin
                        x_addr  = mem_addr;
                        x_we    = mem_we;
                        x_wdata = mem_wdata;
                    end
                    nacc++;
                end
                if (rf_we) begin
                    we_n++;
                    we_cyc = cyc;
                    got_wa = rf_wa;
                    got_wd = rf_wd;
                    rf1[rf_wa] = rf_wd;
                end
                if (retire) begin
                    ret = cyc;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
            chk({vecs[v].name, "_retire_cycle"}, ret, vecs[v].exp_cyc);
            chk({vecs[v].name, "_rf_we_count"}, we_n, vecs[v].exp_we);
            if (vecs[v].exp_we != 0) begin
                chk({vecs[v].name, "_rf_we_cycle"}, we_cyc, vecs[v].exp_we_cyc);
                chk({vecs[v].name, "_rf_wa"}, got_wa, vecs[v].exp_wa);
                chk({vecs[v].name, "_rf_wd"}, got_wd, vecs[v].exp_wd);
            end
            if (vecs[v].is_ld || vecs[v].is_st) begin
                chk({vecs[v].name, "_mem_addr"}, x_addr, vecs[v].exp_addr);
                chk({vecs[v].name, "_mem_we"}, x_we, vecs[v].is_st);
                if (vecs[v].is_st) chk({vecs[v].name, "_mem_wdata"}, x_wdata, vecs[v].exp_wdata);
            end else begin
                chk({vecs[v].name, "_mem_xfers"}, nacc, 1);
            end
            chk({vecs[v].name, "_req_stable"}, stable, 1'b1);
            @(negedge clk);
            chk({vecs[v].name, "_pc_after"}, pc_out, vecs[v].exp_pc);
            chk({vecs[v].name, "_retire_one_cycle"}, retire, 1'b0);
        end

        // BEQ at pc=5: taken back to 4, not taken to 6
        for (int t = 0; t < 2; t++) begin
            fill_mem1();
            for (int i = 0; i < 5; i++) mem1[i] = 16'h6000;
            mem1[5] = 16'h53FE;
            rf1[1]  = 16'h3;
            rf1[2]  = (t == 0) ? 16'h3 : 16'h4;
            fw = 0;
            mw = 0;
            do_reset();
            start1();
            wait_retires(6, 60, got);
            chk("beq_pc5_retires", got, 6);
            chk((t == 0) ? "beq_pc5_taken" : "beq_pc5_not_taken", pc_out,
                (t == 0) ? 16'h4 : 16'h6);
        end

        // PC wrap: branch to 0xFFFF, then a NOP there wraps to 0
        fill_mem1();
        mem1[0]   = 16'h53FE;
        mem1[255] = 16'h6000;
        rf1[1]    = 16'h9;
        rf1[2]    = 16'h9;
        do_reset();
        start1();
        wait_retires(1, 20, got);
        chk("wrap_pc_ffff", pc_out, 16'hFFFF);
        wait_retires(1, 20, got);
        chk("wrap_pc_zero", pc_out, 16'h0);

        // HALT: halted, no requests, pc frozen, run ignored
        fill_mem1();
        do_reset();
        start1();
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (halted) seen = 1'b1;
        end
        chk("halt_reached", seen, 1'b1);
        req_cnt = 0;
        ret_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            run = c[0];
            @(negedge clk);
            if (mem_req) req_cnt++;
            if (retire) ret_cnt++;
        end
        run = 1'b0;
        chk("halt_no_req", req_cnt, 0);
        chk("halt_no_retire", ret_cnt, 0);
        chk("halt_still_halted", halted, 1'b1);
        chk("halt_pc_frozen", pc_out, 16'h0);

        // Asynchronous reset during a stalled fetch at pc=1
        fill_mem1();
        mem1[0] = 16'h6000;
        fw = 0;
        mw = 5;
        do_reset();
        start1();
        wait_retires(1, 20, got);
        chk("rst_fetch_waiting", {mem_req, mem_ack, mem_addr}, {1'b1, 1'b0, 16'h1});
        #2 reset = 1'b1;
        #1;
        chk("rst_async_req_drop", mem_req, 1'b0);
        chk("rst_async_pc", pc_out, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle_after", {mem_req, retire, halted}, 3'b000);

        // Wider geometry: ADD then LOAD then HALT
        for (int i = 0; i < 256; i++) mem2[i] = 32'h0000_E000;
        for (int i = 0; i < 8; i++) rf2[i] = '0;
        mem2[0]    = 32'h0000_1707;  // ADD r5 = r6 + r7
        mem2[1]    = 32'h0000_91FD;  // LOAD r4 = mem[r3 - 3]
        mem2[8'h3D] = 32'hCAFE_F00D;
        rf2[6] = 32'h1234_5678;
        rf2[7] = 32'h0FED_CBA8;
        rf2[3] = 32'h0000_0040;
        do_reset();
        @(negedge clk);
        run2 = 1'b1;
        @(negedge clk);
        run2 = 1'b0;
        for (int c = 0; c < 40 && !halted2; c++) begin
            @(negedge clk);
            if (rf_we2) rf2[rf_wa2] = rf_wd2;
        end
        chk("w32_halted", halted2, 1'b1);
        chk("w32_add", rf2[5], 32'h2222_2220);
        chk("w32_load", rf2[4], 32'hCAFE_F00D);
        chk("w32_pc", pc_out2, 16'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
